// File: rtl/mas_alu_pkg.sv
// Shared types, flag indices and saturation limits for the MAS ALU add/sub pipeline.
package mas_alu_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpAdc = 2'd2,
    OpSbb = 2'd3
  } mas_addsub_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Upper bound on datapath width that the limit helpers can describe.
  localparam int unsigned SatMaxW = 256;

  // Largest positive two's-complement value of the given width (0x7F..F).
  function automatic logic [SatMaxW-1:0] sat_pos(input int unsigned width);
    return (SatMaxW'(1) << (width - 1)) - SatMaxW'(1);
  endfunction

  // Most negative two's-complement value of the given width (0x80..0 once truncated).
  function automatic logic [SatMaxW-1:0] sat_neg(input int unsigned width);
    return {SatMaxW{1'b1}} << (width - 1);
  endfunction

endpackage

// File: rtl/mas_alu_addsub_slice.sv
// SW-bit ripple adder slice; also reports the carry into its top bit for overflow detection.
module mas_alu_addsub_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  output logic [SW-1:0] sum_o,
  output logic          c_o,
  output logic          c_msb_o
);

  always_comb begin
    {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};
    c_msb_o      = sum_o[SW-1] ^ a_i[SW-1] ^ b_i[SW-1];
  end

endmodule

// File: rtl/mas_alu_addsub_pipe.sv
// Pipelined add/sub unit: one carry slice per stage, valid/ready with whole-pipe stall.
// Optional clamp-on-overflow enabled by defining MAS_ALU_SAT_EN (adds in_sat port).
module mas_alu_addsub_pipe
  import mas_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef MAS_ALU_SAT_EN
  input  logic             in_sat,
`endif
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam int unsigned L  = STAGES - 1;
  localparam int unsigned NP = (STAGES > 1) ? STAGES - 1 : 1;

  localparam logic [SatMaxW-1:0] PosLimW = sat_pos(WIDTH);
  localparam logic [SatMaxW-1:0] NegLimW = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0]   PosLim  = PosLimW[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   NegLim  = NegLimW[WIDTH-1:0];

  // Per-stage registers; index L is the output register.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];
  logic             sat_q   [STAGES];
  logic [3:0]       flags_q;
  // Skewed operands and inter-slice carry, only between stages.
  logic [WIDTH-1:0] a_q     [NP];
  logic [WIDTH-1:0] b_q     [NP];
  logic             carry_q [NP];

  // Combinational inputs seen by each stage, and what each stage produces.
  logic [WIDTH-1:0] s_a     [STAGES];
  logic [WIDTH-1:0] s_b     [STAGES];
  logic [WIDTH-1:0] s_res   [STAGES];
  logic             s_cin   [STAGES];
  logic [TAG_W-1:0] s_tag   [STAGES];
  logic             s_valid [STAGES];
  logic             s_sat   [STAGES];
  logic [SW-1:0]    sum     [STAGES];
  logic             cout    [STAGES];
  logic             cmsb    [STAGES];
  logic [WIDTH-1:0] res_d   [STAGES];

  logic             adv;
  logic             sat_in;
  mas_addsub_op_e   op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             v_fin;
  logic [WIDTH-1:0] res_fin;
  logic [3:0]       flags_d;

  assign adv       = ~valid_q[L] | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[L];
  assign out_res   = res_q[L];
  assign out_tag   = tag_q[L];
  assign out_flags = flags_q;

`ifdef MAS_ALU_SAT_EN
  assign sat_in = in_sat;
`else
  assign sat_in = 1'b0;
`endif

  // Subtraction is A + ~B + c0, so SBB's carry-in doubles as "no borrow".
  always_comb begin
    op    = mas_addsub_op_e'(in_op);
    b_eff = in_b;
    c0    = 1'b0;
    unique case (op)
      OpAdd: c0 = 1'b0;
      OpSub: begin
        b_eff = ~in_b;
        c0    = 1'b1;
      end
      OpAdc: c0 = in_cin;
      OpSbb: begin
        b_eff = ~in_b;
        c0    = in_cin;
      end
      default: c0 = 1'b0;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign s_a[k]     = in_a;
      assign s_b[k]     = b_eff;
      assign s_res[k]   = '0;
      assign s_cin[k]   = c0;
      assign s_tag[k]   = in_tag;
      assign s_valid[k] = in_valid;
      assign s_sat[k]   = sat_in;
    end else begin : g_rest
      assign s_a[k]     = a_q[k-1];
      assign s_b[k]     = b_q[k-1];
      assign s_res[k]   = res_q[k-1];
      assign s_cin[k]   = carry_q[k-1];
      assign s_tag[k]   = tag_q[k-1];
      assign s_valid[k] = valid_q[k-1];
      assign s_sat[k]   = sat_q[k-1];
    end

    mas_alu_addsub_slice #(
      .SW(SW)
    ) u_slice (
      .a_i    (s_a[k][k*SW +: SW]),
      .b_i    (s_b[k][k*SW +: SW]),
      .c_i    (s_cin[k]),
      .sum_o  (sum[k]),
      .c_o    (cout[k]),
      .c_msb_o(cmsb[k])
    );

    // Slices above k are still zero in the carried-forward result.
    assign res_d[k] = s_res[k] | (WIDTH'(sum[k]) << (k * SW));
  end

  // Last stage: overflow, optional clamp and flags. C and V stay unsaturated.
  always_comb begin
    v_fin   = cmsb[L] ^ cout[L];
    res_fin = res_d[L];
    if (s_sat[L] && v_fin) begin
      // Wrapped MSB set on overflow means the true result was positive.
      res_fin = res_d[L][WIDTH-1] ? PosLim : NegLim;
    end
    flags_d         = '0;
    flags_d[FLAG_N] = res_fin[WIDTH-1];
    flags_d[FLAG_Z] = (res_fin == '0);
    flags_d[FLAG_C] = cout[L];
    flags_d[FLAG_V] = v_fin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        res_q[k]   <= '0;
        tag_q[k]   <= '0;
        sat_q[k]   <= 1'b0;
      end
      for (int unsigned k = 0; k < NP; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        carry_q[k] <= 1'b0;
      end
      flags_q <= '0;
    end else if (adv) begin
      for (int unsigned k = 0; k < L; k++) begin
        valid_q[k] <= s_valid[k];
        res_q[k]   <= res_d[k];
        tag_q[k]   <= s_tag[k];
        sat_q[k]   <= s_sat[k];
        a_q[k]     <= s_a[k];
        b_q[k]     <= s_b[k];
        carry_q[k] <= cout[k];
      end
      valid_q[L] <= s_valid[L];
      res_q[L]   <= res_fin;
      tag_q[L]   <= s_tag[L];
      sat_q[L]   <= s_sat[L];
      flags_q    <= flags_d;
    end
  end

endmodule

// File: tb/tb_mas_alu_addsub_pipe.sv
// Randomised and directed bench for mas_alu_addsub_pipe against a signed/unsigned arithmetic model.
module tb_mas_alu_addsub_pipe;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned EW     = WIDTH + 4 + TAG_W;
`ifdef MAS_ALU_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sat;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  mas_alu_addsub_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef MAS_ALU_SAT_EN
    .in_sat   (in_sat),
`endif
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_flags(out_flags),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic             obs_valid;
  logic             obs_ready;
  logic             obs_acc;
  logic [WIDTH-1:0] obs_res;
  logic [3:0]       obs_flags;
  logic [TAG_W-1:0] obs_tag;
  int               delivered;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: true signed result and unsigned carry/borrow from plain integer arithmetic.
  function automatic logic [WIDTH+3:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic cin,
                                             input logic sat);
    longint sa, sb, ua, ub, ts, smax, smin, ext;
    logic [63:0] t64;
    logic c, v;
    logic [WIDTH-1:0] r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = longint'(a);
    ub   = longint'(b);
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -smax - 1;
    ext  = 0;
    case (op)
      2'd0: ext = 0;
      2'd1: ext = 0;
      2'd2: ext = longint'(cin);
      default: ext = longint'(!cin);
    endcase
    if (op == 2'd0 || op == 2'd2) begin
      ts = sa + sb + ext;
      c  = (ua + ub + ext) >= (longint'(1) <<< WIDTH);
    end else begin
      ts = sa - sb - ext;
      c  = ua >= (ub + ext);
    end
    v   = (ts > smax) || (ts < smin);
    t64 = ts;
    r   = t64[WIDTH-1:0];
    if (sat && SatEn && v) begin
      t64 = (ts > 0) ? smax : smin;
      r   = t64[WIDTH-1:0];
    end
    return {r, r[WIDTH-1], (r == '0), c, v};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sat, input logic [TAG_W-1:0] tag);
    in_op  = op;
    in_a   = a;
    in_b   = b;
    in_cin = cin;
    in_sat = sat;
    in_tag = tag;
  endtask

  // Inputs are set just after a falling edge; observe, score, then wait for the next one.
  task automatic tick();
    #1;
    obs_valid = out_valid;
    obs_ready = in_ready;
    obs_res   = out_res;
    obs_flags = out_flags;
    obs_tag   = out_tag;
    obs_acc   = 1'b0;
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          check("out_beat", 64'({out_res, out_flags, out_tag}), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({model(in_op, in_a, in_b, in_cin, in_sat), in_tag});
        obs_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_one(input string name, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic cin, input logic sat,
                          input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp_res,
                          input logic [3:0] exp_flags);
    int lat;
    drive(op, a, b, cin, sat, tag);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    check({name, "_acc"}, 64'(obs_acc), 64'd1);
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (obs_valid) begin
        lat = i;
        break;
      end
    end
    check({name, "_lat"}, 64'(lat), 64'(STAGES));
    check({name, "_res"}, 64'(obs_res), 64'(exp_res));
    check({name, "_flags"}, 64'(obs_flags), 64'(exp_flags));
    check({name, "_tag"}, 64'(obs_tag), 64'(tag));
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(WIDTH-1){1'b0}}};
      3: return {1'b0, {(WIDTH-1){1'b1}}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    int first, last, cnt, sent;
    delivered = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(2'd0, '0, '0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_res", 64'(out_res), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);

    // Directed arithmetic corners; flags are {N,Z,C,V}.
    send_one("add_wrap", 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'hA,
             32'h0000_0000, 4'b0110);
    send_one("sub_ovf", 2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 4'h3,
             32'h7FFF_FFFF, 4'b0011);
    send_one("sbb_neg", 2'd3, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 4'h5,
             32'hFFFF_FFFE, 4'b1000);
    send_one("adc_ovf", 2'd2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 4'h6,
             32'h8000_0000, 4'b1001);
    send_one("sbb_brw", 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'h7,
             32'hFFFF_FFFF, 4'b1000);
`ifdef MAS_ALU_SAT_EN
    send_one("sat_add", 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4'h1,
             32'h7FFF_FFFF, 4'b0001);
    send_one("sat_sub", 2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h2,
             32'h8000_0000, 4'b1011);
`endif
    send_one("wrap_add", 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h1,
             32'h8000_0000, 4'b1001);

    // Back-to-back: 8 beats must come out on 8 consecutive cycles.
    first = -1;
    last  = -1;
    cnt   = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 8);
      drive(2'($urandom), rand_operand(), rand_operand(), 1'($urandom), 1'($urandom), 4'(i));
      tick();
      if (obs_valid) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    check("b2b_count", 64'(cnt), 64'd8);
    check("b2b_span", 64'(last - first), 64'd7);
    check("b2b_first", 64'(first), 64'(STAGES));

    // Mid-stream stall of 3 cycles while the pipe is full.
    sent      = 0;
    delivered = 0;
    drive(2'($urandom), rand_operand(), rand_operand(), 1'($urandom), 1'($urandom), 4'd8);
    for (int i = 0; i < 30; i++) begin
      out_ready = !(i >= 5 && i <= 7);
      in_valid  = (sent < 8);
      tick();
      if (i >= 5 && i <= 7) check("stall_in_ready", 64'(obs_ready), 64'd0);
      if (obs_acc) begin
        sent++;
        drive(2'($urandom), rand_operand(), rand_operand(), 1'($urandom), 1'($urandom),
              4'(8 + sent));
      end
    end
    check("stall_delivered", 64'(delivered), 64'd8);
    check("stall_drain", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight: none may emerge afterwards.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive(2'($urandom), rand_operand(), rand_operand(), 1'($urandom), 1'($urandom), 4'(i));
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_valid) cnt++;
    end
    check("rst_flush", 64'(cnt), 64'd0);
    send_one("post_rst", 2'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4'hC,
             32'h2345_6789, 4'b0000);

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      drive(2'($urandom), rand_operand(), rand_operand(), 1'($urandom), 1'($urandom),
            TAG_W'($urandom));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
